// File: rtl/ej9_pkg.sv
// Shared constants and helpers for the ej9 five-input logic block.
package ej9_pkg;

   localparam logic [7:0]  F_MINTERMS    = 8'b1100_1101;
   localparam logic [31:0] PRIME_MASK    = 32'hA08A_28AC;
   localparam logic [2:0]  MAJ_THRESHOLD = 3'd3;

   function automatic logic [2:0] popcount5(input logic [4:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 0; k < 5; k++) begin
         n = n + {2'b00, v[k]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ej9_logic.sv
// Purely combinational core of ej9: canonical f, minimized fk, prime, majority, parity.
module ej9_logic
   import ej9_pkg::*;
(
   input  logic [4:0] v,
   output logic       f,
   output logic       g,
   output logic       h,
   output logic       i,
   output logic       fk
);

   logic       a, b, c;
   logic [7:0] minterm;

   assign a = v[4];
   assign b = v[3];
   assign c = v[2];

   // One AND term per minterm of {A,B,C}; f is the OR of the selected terms.
   assign minterm[0] = ~a & ~b & ~c;
   assign minterm[1] = ~a & ~b &  c;
   assign minterm[2] = ~a &  b & ~c;
   assign minterm[3] = ~a &  b &  c;
   assign minterm[4] =  a & ~b & ~c;
   assign minterm[5] =  a & ~b &  c;
   assign minterm[6] =  a &  b & ~c;
   assign minterm[7] =  a &  b &  c;

   assign f  = |(minterm & F_MINTERMS);
   assign fk = b | (~a & ~c);
   assign g  = PRIME_MASK[v];
   assign h  = (popcount5(v) >= MAJ_THRESHOLD);
   assign i  = ^v;

endmodule

// File: rtl/ej9.sv
// ej9 top: combinational core, optional output registers (EJ9_REG_OUT_EN), sticky f/fk mismatch flag.
module ej9
   import ej9_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   input  logic E,
   output logic f,
   output logic g,
   output logic h,
   output logic i,
   output logic fk,
   output logic err
);

   logic f_c, g_c, h_c, i_c, fk_c;

   ej9_logic u_logic (
      .v  ({A, B, C, D, E}),
      .f  (f_c),
      .g  (g_c),
      .h  (h_c),
      .i  (i_c),
      .fk (fk_c)
   );

`ifdef EJ9_REG_OUT_EN
   // Stage p1: registered outputs, one cycle behind the inputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         f  <= 1'b0;
         g  <= 1'b0;
         h  <= 1'b0;
         i  <= 1'b0;
         fk <= 1'b0;
      end else begin
         f  <= f_c;
         g  <= g_c;
         h  <= h_c;
         i  <= i_c;
         fk <= fk_c;
      end
   end
`else
   assign f  = f_c;
   assign g  = g_c;
   assign h  = h_c;
   assign i  = i_c;
   assign fk = fk_c;
`endif

   // Compares the live combinational pair so both builds flag on the same edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (f_c != fk_c) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ej9.sv
// Directed self-checking bench for ej9; follows EJ9_REG_OUT_EN for output latency.
module tb_ej9;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, E = 1'b0;
   logic f, g, h, i, fk, err;

   int checks = 0;
   int fails  = 0;

   ej9 dut (
      .clk(clk), .reset(reset),
      .A(A), .B(B), .C(C), .D(D), .E(E),
      .f(f), .g(g), .h(h), .i(i), .fk(fk), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic exp_f(input logic [4:0] v);
      case (v[4:2])
         3'd0, 3'd2, 3'd3, 3'd6, 3'd7: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic exp_g(input logic [4:0] v);
      int n;
      n = int'(v);
      if (n < 2) return 1'b0;
      for (int d = 2; d < n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic exp_h(input logic [4:0] v);
      int cnt;
      cnt = 0;
      for (int k = 0; k < 5; k++) if (v[k]) cnt++;
      return (cnt >= 3);
   endfunction

   function automatic logic exp_i(input logic [4:0] v);
      return v[0] ^ v[1] ^ v[2] ^ v[3] ^ v[4];
   endfunction

   task automatic check(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Drive V after the falling edge, then sample where the result is valid.
   task automatic apply(input logic [4:0] v);
      @(negedge clk);
      {A, B, C, D, E} = v;
`ifdef EJ9_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic check_all(input string tag, input logic [4:0] v,
                            input logic ef, input logic efk, input logic eg,
                            input logic eh, input logic ei);
      check({tag, ".f"},  f,  ef);
      check({tag, ".fk"}, fk, efk);
      check({tag, ".g"},  g,  eg);
      check({tag, ".h"},  h,  eh);
      check({tag, ".i"},  i,  ei);
   endtask

   initial begin
      // Reset held low for two cycles with nonzero inputs present.
      {A, B, C, D, E} = 5'b11111;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.err", err, 1'b0);
`ifdef EJ9_REG_OUT_EN
      check("reset.f",  f,  1'b0);
      check("reset.g",  g,  1'b0);
      check("reset.h",  h,  1'b0);
      check("reset.i",  i,  1'b0);
      check("reset.fk", fk, 1'b0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // Hand-computed vectors.
      apply(5'b00000); check_all("v0",  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(5'b00111); check_all("v7",  5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      apply(5'b10111); check_all("v23", 5'd23, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      apply(5'b11110); check_all("v30", 5'd30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      apply(5'b00010); check_all("v2",  5'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      apply(5'b11111); check_all("v31", 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      apply(5'b11011); check_all("v27", 5'd27, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      apply(5'b00001); check_all("v1",  5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

      // Exhaustive sweep, one value per cycle, against the bench model.
      for (int n = 0; n < 32; n++) begin
         logic [4:0] v;
         v = 5'(n);
         apply(v);
         check($sformatf("sweep%0d.f", n),  f,  exp_f(v));
         check($sformatf("sweep%0d.fk", n), fk, exp_f(v));
         check($sformatf("sweep%0d.g", n),  g,  exp_g(v));
         check($sformatf("sweep%0d.h", n),  h,  exp_h(v));
         check($sformatf("sweep%0d.i", n),  i,  exp_i(v));
         check($sformatf("sweep%0d.f_eq_fk", n), f, fk);
      end
      @(posedge clk);
      #1;
      check("sweep.err", err, 1'b0);

      // A second reset pulse keeps err clear and, when registered, zeroes outputs.
      @(negedge clk);
      {A, B, C, D, E} = 5'b00000;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("reset2.err", err, 1'b0);
`ifdef EJ9_REG_OUT_EN
      check("reset2.f", f, 1'b0);
`else
      check("reset2.f", f, 1'b1);
`endif
      @(negedge clk);
      reset = 1'b1;
      apply(5'b01101); check_all("v13", 5'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("final.err", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
